m5_share_arbiter: RTL and testbench
===================================

# m5_share_arbiter

Round-robin arbiter that shares one modulo-MOD event counter among NREQ requesters. A granted requester keeps ownership until it has fed exactly MOD events, which wraps the counter, or until it drops its request. The block forwards only the owner's events to the counter and reports the count and completion status. It sits in front of the lab's mod-5 counting datapath and turns that single-user counter into a shared resource.

## Interface
- NREQ, 4, number of requesters (2..8)
- MOD, 5, counter modulus (2..16); CW = clog2(MOD), IW = clog2(NREQ)
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  reset, asynchronous, active-high
- req  in  NREQ  level request per requester
- evt  in  NREQ  per-requester single-cycle event (counter "w" input)
- grant  out  NREQ  one-hot ownership, registered
- owner  out  IW  index of current owner (valid when busy)
- w_out  out  1  forwarded event = evt[owner] while state OWN, combinational
- count  out  CW  shared counter value, registered
- done  out  1  1-cycle pulse: owner completed MOD events
- abort  out  1  1-cycle pulse: owner dropped req before completion
- busy  out  1  high in states OWN and REL

## Operation
- States: IDLE, OWN, REL (encoding in package).
- IDLE: grant=0, count=0. If any req is set, pick the first set bit scanning upward from ptr, wrapping modulo NREQ. Load owner, set grant[owner], go to OWN. No request: stay in IDLE.
- OWN: evt bits of non-owners are ignored. When evt[owner]=1, count <= count+1. When count=MOD-1 and evt[owner]=1, count <= 0, done=1 next cycle, go to REL.
- OWN, req[owner]=0 without a completing event: count <= 0, abort=1 next cycle, go to REL.
- Simultaneous completing event and request drop in the same cycle: treated as completion. Sets done only, never abort.
- REL: grant=0 for exactly one cycle. ptr <= owner+1 mod NREQ. Go to IDLE. The pending winner is re-evaluated in IDLE, so no requester is granted twice in a row while another is requesting.
- Count arithmetic is unsigned and width CW. Values MOD..2^CW-1 are unreachable. If one is detected, force count to 0 and go to REL with abort.
- done and abort are mutually exclusive and never assert in IDLE.

## Timing
- Reset (async assert): state=IDLE, ptr=0, owner=0, grant=0, count=0, done=0, abort=0, busy=0. w_out=0 because state≠OWN.
- Reset mid-OWN: grant drops immediately, with no done or abort pulse. After deassertion, arbitration restarts from ptr=0.
- req sampled in IDLE at edge t: grant and busy high after edge t.
- evt[owner] at edge t: count updates after edge t. w_out follows evt[owner] in the same cycle.
- Completing event at edge t: count=0, done=1 and state=REL after t. After t+1: done=0, grant=0, state=IDLE. Earliest next grant is after t+2.
- Minimum turnaround between owners is 3 cycles (OWN end → REL → IDLE → OWN).
- A single continuously requesting user gets a grant every MOD+2 cycles when it pulses evt every cycle.

## Structure
- Package m5_share_pkg: state enum (IDLE, OWN, REL), default NREQ/MOD constants, CW/IW width functions.
- Sub-module rr_pick (combinational): inputs req and ptr, outputs any and idx. Implements the rotating first-set-bit scan; reusable by other arbiters.
- Top module holds the FSM, ptr, owner, grant and count registers.

## Test plan
- Reset then req=4'b0010, owner pulses evt for 5 cycles -> grant=0010 one cycle after req. count steps 1,2,3,4,0. done pulses once. grant is 0 for one cycle in REL.
- req=4'b1111 held, owners pulse evt continuously -> grant order 0001,0010,0100,1000,0001. Each tenure is 5 counted events.
- Owner 2 counts to 3, then drops req -> abort pulse, count=0, no done. Next requester (index 3 or wrap) is granted.
- Non-owner evt pulses during OWN -> count unchanged, w_out=0.
- Count=4 with final evt and req drop in the same cycle -> done=1, abort=0.
- Async reset asserted mid-tenure at count=2 -> grant, count, busy = 0 immediately. After release with req=4'b1000, grant=1000 (scan from ptr=0).

Source files
------------

// File: rtl/m5_share_arbiter_pkg.sv
// Shared types and sizing helpers for the m5 shared-counter arbiter.
package m5_share_pkg;

  // Arbiter FSM states: free, owned by one requester, one-cycle release gap.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OWN  = 2'd1,
    ST_REL  = 2'd2
  } state_e;

  localparam int DEF_NREQ = 4;
  localparam int DEF_MOD  = 5;

  // Counter width: enough bits for 0..MOD-1, never narrower than one bit.
  function automatic int cw_f(input int modulus);
    if (modulus <= 2) begin
      return 1;
    end else begin
      return $clog2(modulus);
    end
  endfunction

  // Owner index width: enough bits for 0..NREQ-1, never narrower than one bit.
  function automatic int iw_f(input int nreq);
    if (nreq <= 2) begin
      return 1;
    end else begin
      return $clog2(nreq);
    end
  endfunction

endpackage

// File: rtl/m5_share_arbiter_if.sv
// Requester-side bus of the shared counter arbiter.
// The requester population drives req/evt; the arbiter drives everything else.
interface m5_share_arbiter_if
  import m5_share_pkg::*;
#(
  parameter int NREQ = DEF_NREQ,
  parameter int MOD  = DEF_MOD
);

  localparam int CW = cw_f(MOD);
  localparam int IW = iw_f(NREQ);

  logic [NREQ-1:0] req;
  logic [NREQ-1:0] evt;
  logic [NREQ-1:0] grant;
  logic [IW-1:0]   owner;
  logic            w_out;
  logic [CW-1:0]   count;
  logic            done;
  logic            abort;
  logic            busy;

  // Requester side.
  modport master (
    output req,
    output evt,
    input  grant,
    input  owner,
    input  w_out,
    input  count,
    input  done,
    input  abort,
    input  busy
  );

  // Arbiter side.
  modport slave (
    input  req,
    input  evt,
    output grant,
    output owner,
    output w_out,
    output count,
    output done,
    output abort,
    output busy
  );

endinterface

// File: rtl/m5_share_arbiter_rr_pick.sv
// Rotating first-set-bit picker: returns the first asserted request at or
// above ptr, wrapping modulo NREQ. Purely combinational.
module rr_pick
  import m5_share_pkg::*;
#(
  parameter int NREQ = DEF_NREQ,
  parameter int IW   = iw_f(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic            any,
  output logic [IW-1:0]   idx
);

  logic [2*NREQ-1:0] rot_s;
  logic [IW-1:0]     off_s;
  logic [IW:0]       sum_s;

  // Rotate so that bit 0 is the requester at ptr, find the lowest set offset,
  // then map the offset back to an absolute index modulo NREQ.
  always_comb begin
    rot_s = {req, req} >> ptr;
    any   = 1'b0;
    off_s = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (rot_s[i]) begin
        any   = 1'b1;
        off_s = IW'(i);
      end else begin
        any   = any;
      end
    end
    sum_s = {1'b0, ptr} + {1'b0, off_s};
    if (sum_s >= (IW + 1)'(NREQ)) begin
      idx = IW'(sum_s - (IW + 1)'(NREQ));
    end else begin
      idx = sum_s[IW-1:0];
    end
  end

endmodule

// File: rtl/m5_share_arbiter.sv
// Round-robin arbiter sharing one modulo-MOD event counter among NREQ users.
// An owner keeps the counter until it feeds MOD events (done) or drops its
// request (abort); a one-cycle release state separates consecutive owners.
module m5_share_arbiter
  import m5_share_pkg::*;
#(
  parameter int NREQ = DEF_NREQ,
  parameter int MOD  = DEF_MOD
) (
  input logic                clk,
  input logic                reset,
  m5_share_arbiter_if.slave  bus
);

  localparam int CW = cw_f(MOD);
  localparam int IW = iw_f(NREQ);

  state_e          state_r, state_s;
  logic [IW-1:0]   ptr_r, ptr_s;
  logic [IW-1:0]   owner_r, owner_s;
  logic [NREQ-1:0] grant_r, grant_s;
  logic [CW-1:0]   count_r, count_s;
  logic            done_r, done_s;
  logic            abort_r, abort_s;
  logic            busy_r, busy_s;

  logic            pick_any_s;
  logic [IW-1:0]   pick_idx_s;
  logic            evt_own_s;
  logic            req_own_s;
  logic            count_bad_s;
  logic            count_last_s;

  rr_pick #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_pick (
    .req (bus.req),
    .ptr (ptr_r),
    .any (pick_any_s),
    .idx (pick_idx_s)
  );

  // Owner-side views of the request and event vectors plus counter decodes.
  always_comb begin
    evt_own_s    = bus.evt[owner_r];
    req_own_s    = bus.req[owner_r];
    count_bad_s  = ({1'b0, count_r} >= (CW + 1)'(MOD));
    count_last_s = (count_r == CW'(MOD - 1));
  end

  // Next-state and next-output logic for the ownership FSM.
  always_comb begin
    state_s = state_r;
    ptr_s   = ptr_r;
    owner_s = owner_r;
    grant_s = grant_r;
    count_s = count_r;
    done_s  = 1'b0;
    abort_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        grant_s = '0;
        count_s = '0;
        if (pick_any_s) begin
          owner_s             = pick_idx_s;
          grant_s[pick_idx_s] = 1'b1;
          state_s             = ST_OWN;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_OWN: begin
        if (count_bad_s) begin
          // Unreachable count value: recover by releasing as an abort.
          count_s = '0;
          grant_s = '0;
          abort_s = 1'b1;
          state_s = ST_REL;
        end else if (evt_own_s && count_last_s) begin
          // Completion wins over a simultaneous request drop.
          count_s = '0;
          grant_s = '0;
          done_s  = 1'b1;
          state_s = ST_REL;
        end else if (!req_own_s) begin
          count_s = '0;
          grant_s = '0;
          abort_s = 1'b1;
          state_s = ST_REL;
        end else if (evt_own_s) begin
          count_s = count_r + CW'(1);
        end else begin
          count_s = count_r;
        end
      end
      ST_REL: begin
        grant_s = '0;
        count_s = '0;
        if (owner_r == IW'(NREQ - 1)) begin
          ptr_s = '0;
        end else begin
          ptr_s = owner_r + IW'(1);
        end
        state_s = ST_IDLE;
      end
      default: begin
        grant_s = '0;
        count_s = '0;
        ptr_s   = '0;
        owner_s = '0;
        state_s = ST_IDLE;
      end
    endcase
    busy_s = (state_s == ST_OWN) || (state_s == ST_REL);
  end

  // State and output registers; async reset returns the block to a free IDLE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= ST_IDLE;
      ptr_r   <= '0;
      owner_r <= '0;
      grant_r <= '0;
      count_r <= '0;
      done_r  <= 1'b0;
      abort_r <= 1'b0;
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      ptr_r   <= ptr_s;
      owner_r <= owner_s;
      grant_r <= grant_s;
      count_r <= count_s;
      done_r  <= done_s;
      abort_r <= abort_s;
      busy_r  <= busy_s;
    end
  end

  assign bus.grant = grant_r;
  assign bus.owner = owner_r;
  assign bus.count = count_r;
  assign bus.done  = done_r;
  assign bus.abort = abort_r;
  assign bus.busy  = busy_r;
  // The forwarded event is combinational so the counter sees it in-cycle.
  assign bus.w_out = (state_r == ST_OWN) ? evt_own_s : 1'b0;

endmodule

// File: tb/tb_m5_share_arbiter.sv
// Scoreboard bench for m5_share_arbiter (NREQ=4, MOD=5).
module tb_m5_share_arbiter;

  logic clk;
  logic reset;

  m5_share_arbiter_if #(.NREQ(4), .MOD(5)) bus ();

  m5_share_arbiter #(.NREQ(4), .MOD(5)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic       done;
    logic       abort;
    logic [1:0] owner;
    logic [2:0] count;
  } end_t;

  logic [3:0] grant_q[$];
  logic [2:0] cnt_q[$];
  end_t       end_q[$];

  int n_checks = 0;
  int n_fail   = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_end(input logic d, input logic a, input logic [1:0] o);
    end_t e;
    e.done  = d;
    e.abort = a;
    e.owner = o;
    e.count = 3'd0;
    end_q.push_back(e);
  endtask

  task automatic push_counts(input int n);
    for (int k = 1; k <= n; k++) begin
      cnt_q.push_back(3'(k % 5));
    end
  endtask

  task automatic check_idle_outputs(input string name);
    check({name, "_grant"}, 32'(bus.grant), 32'd0);
    check({name, "_count"}, 32'(bus.count), 32'd0);
    check({name, "_busy"},  32'(bus.busy),  32'd0);
    check({name, "_done"},  32'(bus.done),  32'd0);
    check({name, "_abort"}, 32'(bus.abort), 32'd0);
    check({name, "_w_out"}, 32'(bus.w_out), 32'd0);
  endtask

  task automatic drain(input string name, input int budget);
    int n;
    n = 0;
    while ((grant_q.size() + cnt_q.size() + end_q.size()) != 0 && n < budget) begin
      tick();
      n++;
    end
    check({name, "_drain"}, 32'(grant_q.size() + cnt_q.size() + end_q.size()), 32'd0);
  endtask

  // Monitor: compares every grant start, counted event and end pulse against the queues.
  initial begin
    logic       cnt_pend;
    logic [3:0] prev_grant;
    logic [2:0] exp_c;
    logic [3:0] exp_g;
    end_t       e;
    cnt_pend   = 1'b0;
    prev_grant = 4'd0;
    forever begin
      @(negedge clk);
      if (reset) begin
        cnt_pend   = 1'b0;
        prev_grant = 4'd0;
      end else begin
        if (cnt_pend) begin
          if (cnt_q.size() == 0) begin
            check("count_unexpected", 32'(bus.count), 32'hffff);
          end else begin
            exp_c = cnt_q.pop_front();
            check("count_step", 32'(bus.count), 32'(exp_c));
          end
        end
        cnt_pend = bus.w_out;
        if (bus.grant != 4'd0 && prev_grant == 4'd0) begin
          if (grant_q.size() == 0) begin
            check("grant_unexpected", 32'(bus.grant), 32'd0);
          end else begin
            exp_g = grant_q.pop_front();
            check("grant_order", 32'(bus.grant), 32'(exp_g));
          end
        end
        prev_grant = bus.grant;
        if (bus.done || bus.abort) begin
          if (end_q.size() == 0) begin
            check("end_unexpected", 32'({bus.done, bus.abort}), 32'd0);
          end else begin
            e = end_q.pop_front();
            check("end_pulse", 32'({bus.done, bus.abort, bus.owner, bus.count}),
                  32'({e.done, e.abort, e.owner, e.count}));
          end
        end
      end
    end
  end

  // Stimulus.
  initial begin
    reset   = 1'b1;
    bus.req = 4'd0;
    bus.evt = 4'd0;
    repeat (2) @(posedge clk);
    #1;
    check_idle_outputs("reset");
    reset = 1'b0;
    tick();
    check_idle_outputs("idle_noreq");

    // Single requester 1 completes a full tenure.
    bus.req = 4'b0010;
    grant_q.push_back(4'b0010);
    tick();
    check("s1_grant", 32'(bus.grant), 32'b0010);
    check("s1_busy", 32'(bus.busy), 32'd1);
    bus.evt = 4'b0010;
    push_counts(5);
    push_end(1'b1, 1'b0, 2'd1);
    #1;
    check("s1_w_out", 32'(bus.w_out), 32'd1);
    repeat (5) tick();
    bus.evt = 4'd0;
    bus.req = 4'd0;
    check("s1_rel_grant", 32'(bus.grant), 32'd0);
    check("s1_rel_busy", 32'(bus.busy), 32'd1);
    tick();
    check("s1_idle_busy", 32'(bus.busy), 32'd0);
    drain("s1", 10);

    // All requesting with continuous events: round-robin from ptr=0.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int k = 0; k < 5; k++) begin
      grant_q.push_back(4'b0001 << (k % 4));
      push_counts(5);
      push_end(1'b1, 1'b0, 2'(k % 4));
    end
    bus.req = 4'b1111;
    bus.evt = 4'b1111;
    drain("s2", 60);
    bus.req = 4'd0;
    bus.evt = 4'd0;
    tick();

    // Owner 2 counts to 3, non-owner events ignored, then drops req.
    bus.req = 4'b1100;
    grant_q.push_back(4'b0100);
    tick();
    bus.evt = 4'b0100;
    push_counts(3);
    repeat (3) tick();
    bus.evt = 4'b1011;
    tick();
    tick();
    check("s3_nonowner_count", 32'(bus.count), 32'd3);
    check("s3_nonowner_w_out", 32'(bus.w_out), 32'd0);
    bus.evt = 4'd0;
    bus.req = 4'b1000;
    push_end(1'b0, 1'b1, 2'd2);
    grant_q.push_back(4'b1000);
    tick();
    check("s3_abort_count", 32'(bus.count), 32'd0);
    drain("s3", 10);

    // Owner 3: final event and request drop together count as completion.
    bus.evt = 4'b1000;
    push_counts(5);
    push_end(1'b1, 1'b0, 2'd3);
    repeat (4) tick();
    check("s5_count4", 32'(bus.count), 32'd4);
    bus.req = 4'd0;
    tick();
    bus.evt = 4'd0;
    check("s5_done", 32'({bus.done, bus.abort}), 32'b10);
    drain("s5", 10);

    // Async reset in the middle of a tenure at count 2.
    bus.req = 4'b0001;
    grant_q.push_back(4'b0001);
    drain("s6_grant", 10);
    bus.evt = 4'b0001;
    push_counts(2);
    tick();
    tick();
    bus.evt = 4'd0;
    @(negedge clk);
    #1;
    reset = 1'b1;
    #1;
    check_idle_outputs("midreset");
    tick();
    reset   = 1'b0;
    bus.req = 4'b1000;
    grant_q.push_back(4'b1000);
    drain("s6_regrant", 10);
    check("s6_owner", 32'(bus.owner), 32'd3);
    bus.req = 4'd0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global safety net against a hung run.
  initial begin
    #100000;
    $display("FAIL global_timeout: got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule
